gol_edit_controller: RTL and testbench

//  Parametrised user-input front end for the Game of Life engine. Edge-detects the pause, move, toggle and clear

---
 rtl/gol_edit_controller.sv | 151 +++++++++++++++
 tb/tb_gol_edit_controller.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_edit_controller.sv
// Game of Life user-input front end: button edges, cursor with auto-repeat,
// shadow-grid editing and a valid/ready load of the edited grid into the engine.
module gol_edit_controller #(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 16,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pause_btn,
  input  logic                        left_btn,
  input  logic                        right_btn,
  input  logic                        up_btn,
  input  logic                        down_btn,
  input  logic                        toggle_btn,
  input  logic                        clear_btn,
  input  logic [GRID_W*GRID_H-1:0]    game_grid,
  input  logic                        load_ready,
  output logic                        run,
  output logic                        load_valid,
  output logic [GRID_W*GRID_H-1:0]    load_grid,
  output logic [$clog2(GRID_W)-1:0]   cur_x,
  output logic [$clog2(GRID_H)-1:0]   cur_y,
  output logic                        cur_alive,
  output logic                        edit_pulse
);

  localparam int N  = GRID_W * GRID_H;
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] C_END = CW'(REPEAT_DELAY + REPEAT_RATE);

  typedef enum logic [1:0] {
    S_RUN,
    S_EDIT,
    S_COMMIT
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]    shadow;
  logic            pause_q, tog_q, clr_q;
  logic [3:0]      mv, mv_q;
  logic [CW-1:0]   cnt, cnt_nx, cnt_cur;
  logic            pause_p, tog_p, clr_p;
  logic            edit, rep_hit, step;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic [IW-1:0]   tidx, cidx;

  assign mv      = {left_btn, right_btn, up_btn, down_btn};
  assign pause_p = pause_btn & ~pause_q;
  assign tog_p   = toggle_btn & ~tog_q;
  assign clr_p   = clear_btn & ~clr_q;
  assign edit    = (state == S_EDIT);

  assign run        = (state == S_RUN);
  assign load_valid = (state == S_COMMIT);
  assign load_grid  = shadow;

  assign cidx      = IW'(cur_y) * IW'(GRID_W) + IW'(cur_x);
  assign cur_alive = shadow[cidx];

  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN:    if (pause_p)    state_nx = S_EDIT;
      S_EDIT:   if (pause_p)    state_nx = S_COMMIT;
      S_COMMIT: if (load_ready) state_nx = S_RUN;
      default:                  state_nx = S_RUN;
    endcase
  end

  // cnt_cur is the number of cycles the current move vector has been held
  always_comb begin
    cnt_cur = cnt + CW'(1);
    rep_hit = 1'b0;
    cnt_nx  = '0;
    if (mv != 4'd0 && mv == mv_q && REPEAT_DELAY != 0) begin
      rep_hit = (cnt_cur == C_DLY) || (cnt_cur == C_END);
      cnt_nx  = (cnt_cur == C_END) ? C_DLY : cnt_cur;
    end
    step = (mv != 4'd0) && ((mv != mv_q) || rep_hit);
  end

  always_comb begin
    nx = cur_x;
    ny = cur_y;
    if (step && edit) begin
      unique case (1'b1)
        right_btn && !left_btn:
          nx = (cur_x == XMAX) ? ((WRAP != 0) ? '0 : XMAX) : cur_x + XW'(1);
        left_btn && !right_btn:
          nx = (cur_x == '0) ? ((WRAP != 0) ? XMAX : '0) : cur_x - XW'(1);
        default: nx = cur_x;
      endcase
      unique case (1'b1)
        down_btn && !up_btn:
          ny = (cur_y == YMAX) ? ((WRAP != 0) ? '0 : YMAX) : cur_y + YW'(1);
        up_btn && !down_btn:
          ny = (cur_y == '0) ? ((WRAP != 0) ? YMAX : '0) : cur_y - YW'(1);
        default: ny = cur_y;
      endcase
    end
    tidx = IW'(ny) * IW'(GRID_W) + IW'(nx);
  end

  // previous-button state resets high so a held button makes no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      edit_pulse <= 1'b0;
      cnt        <= '0;
      pause_q    <= 1'b1;
      tog_q      <= 1'b1;
      clr_q      <= 1'b1;
      mv_q       <= 4'hf;
    end else begin
      pause_q    <= pause_btn;
      tog_q      <= toggle_btn;
      clr_q      <= clear_btn;
      mv_q       <= mv;
      cnt        <= cnt_nx;
      edit_pulse <= edit & (tog_p | clr_p);
      if (state == S_RUN) begin
        shadow <= game_grid;
      end else if (edit) begin
        cur_x <= nx;
        cur_y <= ny;
        if (clr_p)      shadow       <= '0;
        else if (tog_p) shadow[tidx] <= ~shadow[tidx];
      end
    end
  end

endmodule

// File: tb/tb_gol_edit_controller.sv
// Directed bench for gol_edit_controller: a wrapping 16x16 instance is checked
// throughout, a clamping twin sees the same stimulus for the edge cases.
module tb_gol_edit_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pause_btn = 1'b0, left_btn = 1'b0, right_btn = 1'b0;
  logic up_btn = 1'b0, down_btn = 1'b0;
  logic toggle_btn = 1'b0, clear_btn = 1'b0;
  logic [255:0] game_grid = '0;
  logic load_ready = 1'b0;

  logic         run0, lv0, alive0, ep0;
  logic [255:0] grid0;
  logic [3:0]   x0, y0;
  logic         run1, lv1, alive1, ep1;
  logic [255:0] grid1;
  logic [3:0]   x1, y1;

  int errors = 0;
  int checks = 0;
  logic [255:0] exp;

  always #5 clk = ~clk;

  gol_edit_controller #(.WRAP(1)) u0 (
    .clk(clk), .reset(reset), .pause_btn(pause_btn),
    .left_btn(left_btn), .right_btn(right_btn),
    .up_btn(up_btn), .down_btn(down_btn),
    .toggle_btn(toggle_btn), .clear_btn(clear_btn),
    .game_grid(game_grid), .load_ready(load_ready),
    .run(run0), .load_valid(lv0), .load_grid(grid0),
    .cur_x(x0), .cur_y(y0), .cur_alive(alive0), .edit_pulse(ep0)
  );

  gol_edit_controller #(.WRAP(0)) u1 (
    .clk(clk), .reset(reset), .pause_btn(pause_btn),
    .left_btn(left_btn), .right_btn(right_btn),
    .up_btn(up_btn), .down_btn(down_btn),
    .toggle_btn(toggle_btn), .clear_btn(clear_btn),
    .game_grid(game_grid), .load_ready(load_ready),
    .run(run1), .load_valid(lv1), .load_grid(grid1),
    .cur_x(x1), .cur_y(y1), .cur_alive(alive1), .edit_pulse(ep1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    right_btn = 1'b1;
    tick();
    tick();
    checks++;
    if (x0 !== 4'd0 || y0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", x0, y0);
    end
    checks++;
    if (run0 !== 1'b1 || lv0 !== 1'b0 || ep0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags run=%b lv=%b ep=%b exp 1 0 0", run0, lv0, ep0);
    end
    checks++;
    if (grid0 !== '0) begin
      errors++;
      $display("FAIL reset_grid got=%h exp=0", grid0);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (x0 !== 4'd0 || run0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_held_right x=%0d run=%b exp x=0 run=1", x0, run0);
    end
    right_btn = 1'b0;
    tick();
  endtask

  task automatic test_run_pause();
    game_grid = 256'h1;
    tick();
    checks++;
    if (grid0 !== 256'h1) begin
      errors++;
      $display("FAIL run_track got=%h exp=1", grid0);
    end
    pause_btn = 1'b1;
    tick();
    checks++;
    if (run0 !== 1'b0 || lv0 !== 1'b0) begin
      errors++;
      $display("FAIL pause_edit run=%b lv=%b exp 0 0", run0, lv0);
    end
    pause_btn = 1'b0;
    game_grid = '1;
    tick();
    tick();
    checks++;
    if (grid0 !== 256'h1) begin
      errors++;
      $display("FAIL edit_frozen got=%h exp=1", grid0);
    end
  endtask

  task automatic test_wrap();
    left_btn = 1'b1;
    tick();
    checks++;
    if (x0 !== 4'd15 || y0 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_left got=(%0d,%0d) exp=(15,0)", x0, y0);
    end
    checks++;
    if (x1 !== 4'd0) begin
      errors++;
      $display("FAIL clamp_left got=%0d exp=0", x1);
    end
    left_btn = 1'b0;
    tick();
    up_btn = 1'b1;
    tick();
    checks++;
    if (x0 !== 4'd15 || y0 !== 4'd15) begin
      errors++;
      $display("FAIL wrap_up got=(%0d,%0d) exp=(15,15)", x0, y0);
    end
    checks++;
    if (x1 !== 4'd0 || y1 !== 4'd0) begin
      errors++;
      $display("FAIL clamp_up got=(%0d,%0d) exp=(0,0)", x1, y1);
    end
    up_btn = 1'b0;
    tick();
    right_btn = 1'b1;
    down_btn = 1'b1;
    tick();
    checks++;
    if (x0 !== 4'd0 || y0 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_diag got=(%0d,%0d) exp=(0,0)", x0, y0);
    end
    checks++;
    if (x1 !== 4'd1 || y1 !== 4'd1) begin
      errors++;
      $display("FAIL clamp_diag got=(%0d,%0d) exp=(1,1)", x1, y1);
    end
    right_btn = 1'b0;
    down_btn = 1'b0;
    tick();
  endtask

  task automatic test_repeat();
    right_btn = 1'b1;
    repeat (24) tick();
    checks++;
    if (x0 !== 4'd1) begin
      errors++;
      $display("FAIL repeat_pre_delay x=%0d exp=1", x0);
    end
    tick();
    checks++;
    if (x0 !== 4'd2) begin
      errors++;
      $display("FAIL repeat_first x=%0d exp=2", x0);
    end
    repeat (15) tick();
    checks++;
    if (x0 !== 4'd4) begin
      errors++;
      $display("FAIL repeat_40 x=%0d exp=4", x0);
    end
    left_btn = 1'b1;
    repeat (30) tick();
    checks++;
    if (x0 !== 4'd4) begin
      errors++;
      $display("FAIL repeat_cancel x=%0d exp=4", x0);
    end
    left_btn = 1'b0;
    right_btn = 1'b0;
    tick();
  endtask

  task automatic test_toggle();
    left_btn = 1'b1;
    tick();
    left_btn = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      down_btn = 1'b1;
      tick();
      down_btn = 1'b0;
      tick();
    end
    checks++;
    if (x0 !== 4'd3 || y0 !== 4'd2) begin
      errors++;
      $display("FAIL toggle_pos got=(%0d,%0d) exp=(3,2)", x0, y0);
    end
    toggle_btn = 1'b1;
    tick();
    exp = 256'h1;
    exp[35] = 1'b1;
    checks++;
    if (grid0 !== exp) begin
      errors++;
      $display("FAIL toggle_bit35 got=%h exp=%h", grid0, exp);
    end
    checks++;
    if (ep0 !== 1'b1 || alive0 !== 1'b1) begin
      errors++;
      $display("FAIL toggle_flags ep=%b alive=%b exp 1 1", ep0, alive0);
    end
    toggle_btn = 1'b0;
    tick();
    checks++;
    if (ep0 !== 1'b0) begin
      errors++;
      $display("FAIL toggle_pulse_width ep=%b exp=0", ep0);
    end
    right_btn = 1'b1;
    toggle_btn = 1'b1;
    tick();
    exp[36] = 1'b1;
    checks++;
    if (grid0 !== exp || x0 !== 4'd4) begin
      errors++;
      $display("FAIL move_toggle x=%0d got=%h exp=%h", x0, grid0, exp);
    end
    right_btn = 1'b0;
    toggle_btn = 1'b0;
    tick();
    toggle_btn = 1'b1;
    clear_btn = 1'b1;
    tick();
    checks++;
    if (grid0 !== '0 || ep0 !== 1'b1 || alive0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins ep=%b alive=%b got=%h exp=0", ep0, alive0, grid0);
    end
    toggle_btn = 1'b0;
    clear_btn = 1'b0;
    tick();
  endtask

  task automatic test_commit();
    left_btn = 1'b1;
    toggle_btn = 1'b1;
    pause_btn = 1'b1;
    tick();
    exp = '0;
    exp[35] = 1'b1;
    checks++;
    if (lv0 !== 1'b1 || run0 !== 1'b0) begin
      errors++;
      $display("FAIL commit_enter lv=%b run=%b exp 1 0", lv0, run0);
    end
    checks++;
    if (grid0 !== exp || x0 !== 4'd3) begin
      errors++;
      $display("FAIL commit_edits x=%0d got=%h exp=%h", x0, grid0, exp);
    end
    left_btn = 1'b0;
    toggle_btn = 1'b0;
    pause_btn = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      toggle_btn = (i % 2 == 0);
      clear_btn = (i % 2 == 0);
      right_btn = (i % 2 == 0);
      pause_btn = (i % 2 == 0);
      tick();
      checks++;
      if (grid0 !== exp || lv0 !== 1'b1 || x0 !== 4'd3 || ep0 !== 1'b0) begin
        errors++;
        $display("FAIL commit_hold%0d lv=%b x=%0d ep=%b got=%h exp=%h",
                 i, lv0, x0, ep0, grid0, exp);
      end
    end
    toggle_btn = 1'b0;
    clear_btn = 1'b0;
    right_btn = 1'b0;
    pause_btn = 1'b0;
    tick();
    load_ready = 1'b1;
    tick();
    checks++;
    if (lv0 !== 1'b0 || run0 !== 1'b1) begin
      errors++;
      $display("FAIL commit_done lv=%b run=%b exp 0 1", lv0, run0);
    end
    load_ready = 1'b0;
    tick();
    checks++;
    if (grid0 !== '1) begin
      errors++;
      $display("FAIL run_resume got=%h exp=all ones", grid0);
    end
  endtask

  task automatic test_reset_commit();
    for (int i = 0; i < 2; i++) begin
      pause_btn = 1'b1;
      tick();
      pause_btn = 1'b0;
      tick();
    end
    checks++;
    if (lv0 !== 1'b1) begin
      errors++;
      $display("FAIL commit_again lv=%b exp=1", lv0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (lv0 !== 1'b0 || run0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_commit lv=%b run=%b exp 0 1", lv0, run0);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_run_pause();
    test_wrap();
    test_repeat();
    test_toggle();
    test_commit();
    test_reset_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
